// File: rtl/seq_csa_accumulator_pkg.sv
// Shared types and width helpers for the sequential carry-save accumulator.
package seq_csa_accumulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Accumulator width: operand width plus guard bits for operand-count growth.
    function automatic int unsigned acc_width(input int unsigned w, input int unsigned cw);
        return w + cw;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/seq_csa_accumulator_row.sv
// N-bit 3:2 compressor row; carry is returned unshifted (bit i weights 2^(i+1)).
module csa_row #(
    parameter int unsigned N = 12
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    output logic [N-1:0] sum,
    output logic [N-1:0] carry
);

    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (carry[i])
        );
    end

endmodule

// File: rtl/seq_csa_accumulator.sv
// Multi-operand unsigned adder: folds one operand per cycle into a redundant
// sum/carry pair, then resolves it with a single carry-propagate add.
module seq_csa_accumulator
    import seq_csa_accumulator_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W+CW-1:0]   out_sum,
    output logic [CW-1:0]     out_count,
    output logic              out_ovf
);

    localparam int unsigned ACC_W = acc_width(W, CW);
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t             state, state_d;
    logic [ACC_W-1:0]   s_q, s_d;
    logic [ACC_W-1:0]   c_q, c_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   sum_d;
    logic [CW-1:0]      count_d;
    logic               ovf_out_d;
    logic               ready_d;
    logic               valid_d;

    logic               accept;
    logic [ACC_W-1:0]   x;
    logic [ACC_W-1:0]   row_sum;
    logic [ACC_W-1:0]   row_carry;

    assign accept = in_valid && in_ready;
    assign x      = ACC_W'(in_data);

    csa_row #(
        .N (ACC_W)
    ) u_row (
        .a     (s_q),
        .b     (c_q),
        .c     (x),
        .sum   (row_sum),
        .carry (row_carry)
    );

    // Next-state, datapath and output logic.
    always_comb begin
        state_d   = state;
        s_d       = s_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        sum_d     = out_sum;
        count_d   = out_count;
        ovf_out_d = out_ovf;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    s_d     = x;
                    c_d     = '0;
                    cnt_d   = CW'(1);
                    ovf_d   = 1'b0;
                    state_d = in_last ? ST_RESOLVE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    s_d   = row_sum;
                    c_d   = {row_carry[ACC_W-2:0], 1'b0};
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                    ovf_d = ovf_q | (cnt_q == CNT_MAX);
                    if (in_last) begin
                        state_d = ST_RESOLVE;
                    end
                end
            end
            ST_RESOLVE: begin
                sum_d     = s_q + c_q;
                count_d   = cnt_q;
                ovf_out_d = ovf_q;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE) || (state_d == ST_ACCUM);
        valid_d = (state_d == ST_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            s_q       <= '0;
            c_q       <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            s_q       <= s_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            out_sum   <= sum_d;
            out_count <= count_d;
            out_ovf   <= ovf_out_d;
            in_ready  <= ready_d;
            out_valid <= valid_d;
        end
    end

endmodule

// File: tb/tb_seq_csa_accumulator.sv
// Directed bench for seq_csa_accumulator (W=8, CW=4).
module tb_seq_csa_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_sum;
    logic [3:0]  out_count;
    logic        out_ovf;

    int checks = 0;
    int errors = 0;
    logic [31:0] res_q[$];

    seq_csa_accumulator #(
        .W  (8),
        .CW (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every completed result handshake.
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready)
            res_q.push_back({15'd0, out_ovf, out_count, out_sum});
    end

    function automatic logic [31:0] pk(input logic ovf, input logic [3:0] cnt, input logic [11:0] sum);
        return {15'd0, ovf, cnt, sum};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one operand starting at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [7:0] d, input logic l, output int waits);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        waits    = 0;
        while (in_ready !== 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 20) chk("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_res(input string tag, input logic [31:0] exp);
        for (int i = 0; i < 40 && res_q.size() == 0; i++) @(negedge clk);
        if (res_q.size() == 0) begin
            chk({tag, "_timeout"}, 32'(res_q.size()), 32'd1);
        end else begin
            chk(tag, res_q.pop_front(), exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready),  32'd1);
        chk("rst_sum",   32'(out_sum),   32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_ovf",   32'(out_ovf),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single operand: RESOLVE after accept, DONE with result one cycle later.
        send(8'hA5, 1'b1, w);
        chk("single_resolve_valid", 32'(out_valid), 32'd0);
        chk("single_resolve_ready", 32'(in_ready),  32'd0);
        @(negedge clk);
        chk("single_done_valid", 32'(out_valid), 32'd1);
        chk("single_done_out", pk(out_ovf, out_count, out_sum), pk(1'b0, 4'd1, 12'h0A5));
        @(negedge clk);
        chk("single_back_idle_ready", 32'(in_ready),  32'd1);
        chk("single_back_idle_valid", 32'(out_valid), 32'd0);
        wait_res("single_res", pk(1'b0, 4'd1, 12'h0A5));

        // Three operands with input gaps.
        send(8'hFF, 1'b0, w);
        idle(2);
        send(8'hFF, 1'b0, w);
        idle(1);
        send(8'hFF, 1'b1, w);
        wait_res("three_gaps", pk(1'b0, 4'd3, 12'h2FD));

        for (int i = 0; i < 15; i++) send(8'hFF, i == 14, w);
        wait_res("ff_x15", pk(1'b0, 4'd15, 12'hEF1));
        for (int i = 0; i < 16; i++) send(8'hFF, i == 15, w);
        wait_res("ff_x16", pk(1'b1, 4'd15, 12'hFF0));
        for (int i = 0; i < 17; i++) send(8'hFF, i == 16, w);
        wait_res("ff_x17", pk(1'b1, 4'd15, 12'h0EF));

        // Backpressure: result held while out_ready is low.
        out_ready = 1'b0;
        send(8'h10, 1'b0, w);
        send(8'h20, 1'b1, w);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {14'd0, out_valid, in_ready, out_ovf, out_count, out_sum},
                {14'd0, 1'b1, 1'b0, 1'b0, 4'd2, 12'h030});
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(in_ready),  32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        wait_res("bp_res", pk(1'b0, 4'd2, 12'h030));

        // Reset mid-sum aborts with no output.
        for (int i = 0; i < 4; i++) send(8'h01, 1'b0, w);
        rst_n = 1'b0;
        #1;
        chk("midrst_clear", {14'd0, out_valid, in_ready, out_ovf, out_count, out_sum},
            {14'd0, 1'b0, 1'b1, 1'b0, 4'd0, 12'h000});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_no_result", 32'(res_q.size()), 32'd0);
        send(8'h01, 1'b0, w);
        send(8'h02, 1'b1, w);
        wait_res("after_rst", pk(1'b0, 4'd2, 12'h003));

        // Back-to-back sums with in_valid held: next first operand waits RESOLVE+DONE.
        send(8'h11, 1'b0, w);
        send(8'h22, 1'b1, w);
        send(8'h33, 1'b0, w);
        chk("b2b_gap_waits", 32'(w), 32'd2);
        send(8'h44, 1'b1, w);
        wait_res("b2b_first",  pk(1'b0, 4'd2, 12'h033));
        wait_res("b2b_second", pk(1'b0, 4'd2, 12'h077));

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
